// File: rtl/sb_tx_arbiter.sv
// sb_tx_arbiter: round-robin arbiter sharing one sideband TX channel among LTSM requesters with ack timeout and retry.
module sb_tx_arbiter #(
  parameter int SB_MSG_WIDTH = 4,
  parameter int NUM_REQ = 4,
  parameter int ACK_TIMEOUT = 15,
  parameter int MAX_RETRY = 3
) (
  input  logic                            i_clk,
  input  logic                            i_rst,
  input  logic                            i_flush,
  input  logic [NUM_REQ-1:0]              i_req_valid,
  input  logic [NUM_REQ*SB_MSG_WIDTH-1:0] i_req_msg,
  input  logic [NUM_REQ*3-1:0]            i_req_info,
  input  logic                            i_SB_Busy,
  input  logic                            i_falling_edge_busy,
  output logic                            o_tx_msg_valid,
  output logic [SB_MSG_WIDTH-1:0]         o_encoded_SB_msg,
  output logic [2:0]                      o_tx_msg_info,
  output logic [NUM_REQ-1:0]              o_grant,
  output logic [NUM_REQ-1:0]              o_done,
  output logic                            o_timeout_err
);
  localparam int PW = NUM_REQ > 1 ? $clog2(NUM_REQ) : 1;
  localparam int AW = ACK_TIMEOUT > 0 ? $clog2(ACK_TIMEOUT + 1) : 1;
  localparam int RW = MAX_RETRY > 0 ? $clog2(MAX_RETRY + 1) : 1;
  typedef enum logic [1:0] {IDLE, ISSUE, WAIT_ACK, WAIT_DONE} state_t;
  state_t state;
  logic [PW-1:0] rr_ptr, owner, sel, rr_nxt;
  logic [AW-1:0] ack_cnt, ack_nxt;
  logic [RW-1:0] retry_cnt;
  logic [2*NUM_REQ-1:0] rot;
  logic done_now, to_now, grant_now;
  always_comb begin
    rot = {i_req_valid, i_req_valid} >> rr_ptr;
    sel = '0;
    // scanning downward leaves the nearest requester at or after rr_ptr
    for (int i = NUM_REQ - 1; i >= 0; i--)
      if (rot[i]) sel = PW'((int'(rr_ptr) + i) % NUM_REQ);
    ack_nxt = ack_cnt == AW'(ACK_TIMEOUT) ? ack_cnt : ack_cnt + 1'b1;
    rr_nxt = owner == PW'(NUM_REQ - 1) ? '0 : owner + 1'b1;
    grant_now = !i_flush && state == IDLE && |i_req_valid && !i_SB_Busy;
    done_now = !i_flush && i_falling_edge_busy &&
               (state == WAIT_DONE || (state == WAIT_ACK && i_SB_Busy));
    to_now = !i_flush && state == WAIT_ACK && !i_SB_Busy &&
             ack_nxt == AW'(ACK_TIMEOUT) && retry_cnt == RW'(MAX_RETRY);
  end
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state <= IDLE;
      rr_ptr <= '0;
      owner <= '0;
      ack_cnt <= '0;
      retry_cnt <= '0;
      o_tx_msg_valid <= 1'b0;
      o_encoded_SB_msg <= '0;
      o_tx_msg_info <= '0;
      o_grant <= '0;
      o_done <= '0;
      o_timeout_err <= 1'b0;
    end else begin
      o_tx_msg_valid <= 1'b0;
      o_done <= done_now ? o_grant : '0;
      o_timeout_err <= to_now;
      if (i_flush || done_now || to_now) begin
        state <= IDLE;
        o_grant <= '0;
        o_encoded_SB_msg <= '0;
        o_tx_msg_info <= '0;
        ack_cnt <= '0;
        retry_cnt <= '0;
        if (!i_flush) rr_ptr <= rr_nxt;
      end else if (grant_now) begin
        state <= ISSUE;
        owner <= sel;
        o_grant <= NUM_REQ'(1) << sel;
        o_encoded_SB_msg <= i_req_msg[sel * SB_MSG_WIDTH +: SB_MSG_WIDTH];
        o_tx_msg_info <= i_req_info[sel * 3 +: 3];
        o_tx_msg_valid <= 1'b1;
        retry_cnt <= '0;
      end else if (state == ISSUE) begin
        state <= WAIT_ACK;
        ack_cnt <= '0;
      end else if (state == WAIT_ACK) begin
        if (i_SB_Busy) state <= WAIT_DONE;
        else if (ack_nxt == AW'(ACK_TIMEOUT)) begin
          state <= ISSUE;
          o_tx_msg_valid <= 1'b1;
          retry_cnt <= retry_cnt + 1'b1;
          ack_cnt <= ack_nxt;
        end else ack_cnt <= ack_nxt;
      end
    end
  end
endmodule
